// File: rtl/starboy_pkg.sv
// Shared types for the starboy game blocks: move_gen FSM states, move commands and cell colours.
// Also holds the fixed move-priority picker.
package starboy_pkg;

  localparam int unsigned NumMoves = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StIssue = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    MoveRight = 3'd0,
    MoveLeft  = 3'd1,
    MoveRor   = 3'd2,
    MoveRol   = 3'd3,
    MoveDown  = 3'd4
  } move_t;

  typedef enum logic [2:0] {
    ColorBlack  = 3'd0,
    ColorCyan   = 3'd1,
    ColorYellow = 3'd2,
    ColorPurple = 3'd3,
    ColorGreen  = 3'd4,
    ColorRed    = 3'd5,
    ColorBlue   = 3'd6,
    ColorOrange = 3'd7
  } color_t;

  // Fixed priority DOWN > ROR > ROL > RIGHT > LEFT.
  function automatic move_t pick_move(input logic [NumMoves-1:0] pend);
    if (pend[MoveDown])       return MoveDown;
    else if (pend[MoveRor])   return MoveRor;
    else if (pend[MoveRol])   return MoveRol;
    else if (pend[MoveRight]) return MoveRight;
    else                      return MoveLeft;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit debouncer: level follows raw only after raw has differed from it for
// DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (raw != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = raw;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/move_gen.sv
// Turns debounced buttons and a gravity timer into a stream of handshaked move commands.
// Optional build macro MOVE_GEN_AUTO_REPEAT_EN adds auto-repeat on held RIGHT/LEFT/DOWN.
module move_gen
  import starboy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GRAVITY_CYCLES  = 32,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_RATE     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic       active,
  input  logic       move_ack,
  output logic [2:0] move,
  output logic       move_valid,
  output logic       gravity_tick
);

  localparam int unsigned GravW = $clog2(GRAVITY_CYCLES) + 1;

  if (DEBOUNCE_CYCLES == 0 || GRAVITY_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0)
  begin : g_param_check
    $error("move_gen: all cycle parameters must be non-zero");
  end

  logic [4:0] level, level_prev_q, press;

  for (genvar i = 0; i < NumMoves; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[i]),
      .level(level[i])
    );
  end

`ifdef MOVE_GEN_AUTO_REPEAT_EN
  localparam int unsigned RepMax     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW       = $clog2(RepMax) + 1;
  localparam logic [4:0]  RepeatMask = 5'b10011;

  logic [4:0][RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic [4:0]           rep_run_q, rep_run_d, rep_hit;

  // rep_cnt counts cycles since the last press event of a held button.
  always_comb begin
    for (int i = 0; i < NumMoves; i++) begin
      rep_hit[i]   = 1'b0;
      rep_cnt_d[i] = '0;
      rep_run_d[i] = 1'b0;
      if (RepeatMask[i] && level[i]) begin
        rep_hit[i]   = rep_cnt_q[i] == (rep_run_q[i] ? RepW'(REPEAT_RATE) : RepW'(REPEAT_DELAY));
        rep_cnt_d[i] = rep_hit[i] ? RepW'(1) : rep_cnt_q[i] + RepW'(1);
        rep_run_d[i] = rep_run_q[i] | rep_hit[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_run_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_run_q <= rep_run_d;
    end
  end

  assign press = (level & ~level_prev_q) | rep_hit;
`else
  assign press = level & ~level_prev_q;
`endif

  state_t            state_q, state_d;
  move_t             move_q, move_d;
  logic              valid_q, valid_d;
  logic [4:0]        pend_q, pend_d;
  logic [GravW-1:0]  grav_q, grav_d;
  logic              tick_q, grav_wrap, clr;

  always_comb begin
    grav_wrap = active && (grav_q == GravW'(GRAVITY_CYCLES - 1));
    grav_d    = (!active || grav_wrap) ? '0 : grav_q + GravW'(1);

    state_d = state_q;
    move_d  = move_q;
    valid_d = valid_q;
    clr     = 1'b0;
    if (!active) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWait;
        StWait: begin
          if (|pend_q) begin
            state_d = StIssue;
            move_d  = pick_move(pend_q);
            valid_d = 1'b1;
          end
        end
        StIssue: begin
          if (move_ack) begin
            state_d = StWait;
            valid_d = 1'b0;
            clr     = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Duplicate requests collapse onto the already-set bit; the acked bit clears last.
    pend_d = pend_q | ((state_q != StIdle) ? press : 5'b0);
    if (grav_wrap) pend_d[MoveDown] = 1'b1;
    if (clr)       pend_d[move_q]   = 1'b0;
    if (!active)   pend_d           = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      move_q       <= MoveRight;
      valid_q      <= 1'b0;
      pend_q       <= '0;
      grav_q       <= '0;
      tick_q       <= 1'b0;
      level_prev_q <= '0;
    end else begin
      state_q      <= state_d;
      move_q       <= move_d;
      valid_q      <= valid_d;
      pend_q       <= pend_d;
      grav_q       <= grav_d;
      tick_q       <= grav_wrap;
      level_prev_q <= level;
    end
  end

  assign move         = move_q;
  assign move_valid   = valid_q;
  assign gravity_tick = tick_q;

endmodule

// File: tb/tb_move_gen.sv
// Self-checking bench for move_gen: directed scenarios plus a randomized run against a
// cycle-level behavioural model of debounce, pending requests, gravity and the handshake.
module tb_move_gen;

  localparam int Deb      = 4;
  localparam int Grav     = 32;
  localparam int RepDelay = 8;
  localparam int RepRate  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;
  logic       active = 1'b0;
  logic       move_ack = 1'b0;
  logic [2:0] move;
  logic       move_valid;
  logic       gravity_tick;

  always #5 clk = ~clk;

  move_gen #(
    .DEBOUNCE_CYCLES(Deb),
    .GRAVITY_CYCLES (Grav),
    .REPEAT_DELAY   (RepDelay),
    .REPEAT_RATE    (RepRate)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .active      (active),
    .move_ack    (move_ack),
    .move        (move),
    .move_valid  (move_valid),
    .gravity_tick(gravity_tick)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  bit [4:0] m_deb, m_prev, m_pend;
  int       m_run[5];
  int       m_tpress[5];
  int       m_grav, m_cur, m_cyc;
  bit       m_busy, m_in_game, m_tick;

  int dut_xfers;
  int xq[$];
  int tq[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int prio(input bit [4:0] p);
    int order[5] = '{4, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) if (p[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_reset();
    m_deb = '0; m_prev = '0; m_pend = '0;
    for (int i = 0; i < 5; i++) begin
      m_run[i] = 0;
      m_tpress[i] = 0;
    end
    m_grav = 0; m_cur = 0; m_cyc = 0;
    m_busy = 0; m_in_game = 0; m_tick = 0;
  endtask

  // Advance the model by one clock edge, given the inputs seen at that edge.
  task automatic model_step(input logic [4:0] b, input logic act, input logic ack);
    bit [4:0] ev;
    bit [4:0] newp;
    int       age;
    ev = '0;
    for (int i = 0; i < 5; i++) begin
      if (m_deb[i] && !m_prev[i]) begin
        ev[i] = 1'b1;
        m_tpress[i] = m_cyc;
      end
`ifdef MOVE_GEN_AUTO_REPEAT_EN
      else if ((i == 0 || i == 1 || i == 4) && m_deb[i] && m_prev[i]) begin
        age = m_cyc - m_tpress[i];
        if (age >= RepDelay && (age - RepDelay) % RepRate == 0) ev[i] = 1'b1;
      end
`endif
    end
    age = 0;
    for (int i = 0; i < 5; i++) begin
      m_prev[i] = m_deb[i];
      if (b[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == Deb) begin
          m_deb[i] = b[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (!act) begin
      m_in_game = 0; m_busy = 0; m_pend = '0; m_grav = 0; m_tick = 0;
    end else begin
      m_tick = (m_grav == Grav - 1);
      m_grav = m_tick ? 0 : m_grav + 1;
      newp = m_pend;
      if (m_in_game) newp |= ev;
      if (m_tick) newp[4] = 1'b1;
      if (!m_in_game) begin
        m_in_game = 1;
      end else if (m_busy) begin
        if (ack) begin
          newp[m_cur] = 1'b0;
          m_busy = 0;
        end
      end else if (m_pend != 0) begin
        m_cur  = prio(m_pend);
        m_busy = 1;
      end
      m_pend = newp;
    end
    m_cyc++;
  endtask

  task automatic step();
    if (move_valid && move_ack) begin
      dut_xfers++;
      xq.push_back(int'(move));
    end
    @(posedge clk);
    model_step(btn, active, move_ack);
    #1;
    check("valid", int'(move_valid), int'(m_busy));
    check("move", int'(move), m_cur);
    check("tick", int'(gravity_tick), int'(m_tick));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; btn = '0; active = 1'b0; move_ack = 1'b0;
    #2;
    check("rst_valid", int'(move_valid), 0);
    check("rst_move", int'(move), 0);
    check("rst_tick", int'(gravity_tick), 0);
    model_reset();
    dut_xfers = 0;
    xq.delete();
    tq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (move_valid) seen = 1;
    end
    check(tag, int'(seen), 1);
  endtask

  initial begin
    int first;
    int nright;

    // Single press: first valid 6 edges after btn rises, exactly one RIGHT.
    do_reset();
    active = 1; move_ack = 1;
    repeat (2) step();
    btn = 5'b00001;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (move_valid && first < 0) first = k;
    end
    btn = '0;
    repeat (10) step();
    check("s1_latency", first, 6);
    check("s1_xfers", dut_xfers, 1);
    check("s1_move", (xq.size() > 0) ? xq[0] : -1, 0);

    // Glitch rejection.
    do_reset();
    active = 1; move_ack = 1;
    repeat (2) step();
    btn = 5'b00100;
    repeat (3) step();
    btn = '0;
    repeat (12) step();
    check("s2_xfers", dut_xfers, 0);

    // Priority and hold: ROL beats LEFT, held while ack is low.
    do_reset();
    active = 1; move_ack = 0;
    repeat (2) step();
    btn = 5'b01010;
    wait_valid("s3_issue");
    for (int k = 0; k < 5; k++) begin
      check("s3_hold_move", int'(move), 3);
      check("s3_hold_valid", int'(move_valid), 1);
      step();
    end
    move_ack = 1;
    repeat (6) step();
    btn = '0;
    repeat (4) step();
    check("s3_xfers", dut_xfers, 2);
    check("s3_first", (xq.size() > 0) ? xq[0] : -1, 3);
    check("s3_second", (xq.size() > 1) ? xq[1] : -1, 1);

    // Gravity: ticks at 32, 64, 96, each followed by a DOWN.
    do_reset();
    active = 1; move_ack = 1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (gravity_tick) tq.push_back(k);
    end
    check("s4_ticks", tq.size(), 3);
    for (int i = 0; i < 3; i++) check("s4_tick_at", (tq.size() > i) ? tq[i] : -1, 32 * (i + 1));
    check("s4_xfers", dut_xfers, 3);
    for (int i = 0; i < xq.size(); i++) check("s4_down", xq[i], 4);

    // Abort while a move is in flight.
    do_reset();
    active = 1; move_ack = 0;
    repeat (2) step();
    btn = 5'b00001;
    wait_valid("s5_issue");
    active = 0; btn = '0;
    step();
    check("s5_abort_valid", int'(move_valid), 0);
    active = 1; move_ack = 1;
    repeat (20) step();
    check("s5_xfers", dut_xfers, 0);

    // Auto-repeat: RIGHT held for 31 debounced cycles.
    do_reset();
    active = 1; move_ack = 1;
    repeat (2) step();
    btn = 5'b00001;
    repeat (31) step();
    btn = '0;
    repeat (10) step();
    nright = 0;
    foreach (xq[i]) if (xq[i] == 0) nright++;
`ifdef MOVE_GEN_AUTO_REPEAT_EN
    check("s6_repeats", nright, 7);
`else
    check("s6_repeats", nright, 1);
`endif

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
      if (active) begin
        if ($urandom_range(0, 199) == 0) active = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        active = 1;
      end
      move_ack = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
